// File: rtl/motion_pkg.sv
// Shared definitions for the tile motion detector and the red-box overlay:
// default geometry, derived widths, tile-id packing and luma extraction.
package motion_pkg;

    localparam int H_ACTIVE_DEF = 1280;
    localparam int V_ACTIVE_DEF = 720;
    localparam int GX_DEF       = 16;
    localparam int GY_DEF       = 16;

    // Counter width able to hold 0..n-1 (at least one bit).
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int TW_DEF    = H_ACTIVE_DEF / GX_DEF;
    localparam int TH_DEF    = V_ACTIVE_DEF / GY_DEF;
    localparam int LWX_DEF   = cnt_w(TW_DEF);
    localparam int LWY_DEF   = cnt_w(TH_DEF);
    localparam int SUM_W_DEF = $clog2(TW_DEF * TH_DEF * 255 + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EMIT  = 2'd1,
        ST_DRAIN = 2'd2
    } emit_state_t;

    function automatic logic [7:0] tile_id(input logic [3:0] ty, input logic [3:0] tx);
        return {ty, tx};
    endfunction

    // Y = (R + 2G + B) >> 2, truncating; the sum never exceeds 1020.
    function automatic logic [7:0] luma(input logic [23:0] rgb);
        logic [9:0] s;
        s = {2'b00, rgb[23:16]} + {1'b0, rgb[15:8], 1'b0} + {2'b00, rgb[7:0]};
        return s[9:2];
    endfunction

endpackage

// File: rtl/tile_pos_counter.sv
// Pixel-to-tile position tracker shared with the overlay so both stages
// derive identical tile coordinates from the same s_pVDE stream.
module tile_pos_counter
    import motion_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int GX       = GX_DEF,
    parameter int GY       = GY_DEF,
    parameter int LWX      = cnt_w(H_ACTIVE / GX),
    parameter int LWY      = cnt_w(V_ACTIVE / GY)
) (
    input  logic           pclk,
    input  logic           rst_n,
    input  logic           vde_i,
    output logic [LWX-1:0] xl_o,
    output logic [LWY-1:0] yl_o,
    output logic [3:0]     tx_o,
    output logic [3:0]     ty_o,
    output logic           vde_fall_o
);

    localparam int TW = H_ACTIVE / GX;
    localparam int TH = V_ACTIVE / GY;

    logic [LWX-1:0] xl_q, xl_d;
    logic [LWY-1:0] yl_q, yl_d;
    logic [3:0]     tx_q, tx_d;
    logic [3:0]     ty_q, ty_d;
    logic           vde_q;

    assign vde_fall_o = vde_q & ~vde_i;

    always_comb begin
        xl_d = xl_q;
        tx_d = tx_q;
        yl_d = yl_q;
        ty_d = ty_q;
        if (vde_i) begin
            if (xl_q == LWX'(TW - 1)) begin
                xl_d = '0;
                tx_d = (tx_q == 4'(GX - 1)) ? 4'd0 : tx_q + 4'd1;
            end else begin
                xl_d = xl_q + LWX'(1);
            end
        end else begin
            xl_d = '0;
            tx_d = '0;
        end
        // Vertical position moves once per line, at the end of active video.
        if (vde_fall_o) begin
            if (yl_q == LWY'(TH - 1)) begin
                yl_d = '0;
                ty_d = (ty_q == 4'(GY - 1)) ? 4'd0 : ty_q + 4'd1;
            end else begin
                yl_d = yl_q + LWY'(1);
            end
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            xl_q  <= '0;
            yl_q  <= '0;
            tx_q  <= '0;
            ty_q  <= '0;
            vde_q <= 1'b0;
        end else begin
            xl_q  <= xl_d;
            yl_q  <= yl_d;
            tx_q  <= tx_d;
            ty_q  <= ty_d;
            vde_q <= vde_i;
        end
    end

    assign xl_o = xl_q;
    assign yl_o = yl_q;
    assign tx_o = tx_q;
    assign ty_o = ty_q;

endmodule

// File: rtl/tile_motion_vecgen.sv
// Per-tile luma motion detector: sums luma per tile, compares each tile row
// with the previous frame and bursts one motion flag per tile to the overlay.
module tile_motion_vecgen
    import motion_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int GX       = GX_DEF,
    parameter int GY       = GY_DEF,
    parameter int THRESH   = 28800
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic [23:0] s_pData,
    input  logic        s_pVDE,
    output logic        vec_we,
    output logic [7:0]  vec_addr,
    output logic        motion_detected,
    output logic        frame_done,
    output logic [8:0]  motion_count
);

    localparam int TW    = H_ACTIVE / GX;
    localparam int TH    = V_ACTIVE / GY;
    localparam int LWX   = cnt_w(TW);
    localparam int LWY   = cnt_w(TH);
    localparam int TXW   = cnt_w(GX);
    localparam int SUM_W = $clog2(TW * TH * 255 + 1);

    function automatic logic [SUM_W-1:0] abs_diff(input logic [SUM_W-1:0] a,
                                                  input logic [SUM_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    logic [LWX-1:0] unused_xl;
    logic [LWY-1:0] yl;
    logic [3:0]     tx, ty;
    logic           vde_fall;

    tile_pos_counter #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .GX       (GX),
        .GY       (GY),
        .LWX      (LWX),
        .LWY      (LWY)
    ) u_pos (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .vde_i      (s_pVDE),
        .xl_o       (unused_xl),
        .yl_o       (yl),
        .tx_o       (tx),
        .ty_o       (ty),
        .vde_fall_o (vde_fall)
    );

    logic snap_evt;
    assign snap_evt = vde_fall && (yl == LWY'(TH - 1));

    logic [SUM_W-1:0] acc_q  [GX];
    logic [SUM_W-1:0] snap_q [GX];

    // Accumulators must start from zero every frame, so they take the reset.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < GX; i++) acc_q[i] <= '0;
        end else if (snap_evt) begin
            for (int i = 0; i < GX; i++) acc_q[i] <= '0;
        end else if (s_pVDE) begin
            acc_q[tx[TXW-1:0]] <= acc_q[tx[TXW-1:0]] + SUM_W'(luma(s_pData));
        end
    end

    always_ff @(posedge pclk) begin
        if (snap_evt) snap_q <= acc_q;
    end

    emit_state_t    state_q, state_d;
    logic [TXW-1:0] idx_q, idx_d;
    logic [3:0]     row_q, row_d;
    logic           vld_p1_q, vld_p1_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        row_d   = row_q;
        case (state_q)
            ST_IDLE: ;
            ST_EMIT: begin
                if (idx_q == TXW'(GX - 1)) state_d = ST_DRAIN;
                else                       idx_d   = idx_q + TXW'(1);
            end
            ST_DRAIN: begin
                if (!vld_p1_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // A new snapshot always wins and restarts the walk.
        if (snap_evt) begin
            state_d = ST_EMIT;
            idx_d   = '0;
            row_d   = ty;
        end
    end

    // ---- stage 1: previous-frame sum read ----
    logic [SUM_W-1:0] prev_mem [256];
    logic [SUM_W-1:0] prev_p1_q;
    logic [TXW-1:0]   idx_p1_q;

    always_ff @(posedge pclk) begin
        prev_p1_q <= prev_mem[tile_id(row_q, 4'(idx_q))];
        idx_p1_q  <= idx_q;
        if (vld_p1_q) prev_mem[tile_id(row_q, 4'(idx_p1_q))] <= snap_q[idx_p1_q];
    end

    // ---- stage 2: compare and register outputs ----
    logic             prev_valid_q, prev_valid_d;
    logic [SUM_W-1:0] diff_p2;
    logic             flag_p2;
    logic             we_q, we_d;
    logic [7:0]       addr_q, addr_d;
    logic             md_q, md_d;
    logic             fdone_pend_q, fdone_pend_d;
    logic             frame_done_q, frame_done_d;
    logic [8:0]       cnt_q, cnt_d;
    logic [8:0]       mcount_q, mcount_d;

    always_comb begin
        diff_p2      = abs_diff(snap_q[idx_p1_q], prev_p1_q);
        flag_p2      = prev_valid_q && (32'(diff_p2) > THRESH);
        vld_p1_d     = (state_q == ST_EMIT) && !snap_evt;
        we_d         = vld_p1_q && !snap_evt;
        addr_d       = addr_q;
        md_d         = md_q;
        if (we_d) begin
            addr_d = tile_id(row_q, 4'(idx_p1_q));
            md_d   = flag_p2;
        end
        fdone_pend_d = we_d && (row_q == 4'(GY - 1)) && (idx_p1_q == TXW'(GX - 1));
        frame_done_d = fdone_pend_q;
        cnt_d        = cnt_q;
        mcount_d     = mcount_q;
        prev_valid_d = prev_valid_q;
        if (fdone_pend_q) begin
            mcount_d     = cnt_q;
            cnt_d        = '0;
            prev_valid_d = 1'b1;
        end else if (we_d && flag_p2) begin
            cnt_d = cnt_q + 9'd1;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            row_q        <= '0;
            vld_p1_q     <= 1'b0;
            prev_valid_q <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            md_q         <= 1'b0;
            fdone_pend_q <= 1'b0;
            frame_done_q <= 1'b0;
            cnt_q        <= '0;
            mcount_q     <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            row_q        <= row_d;
            vld_p1_q     <= vld_p1_d;
            prev_valid_q <= prev_valid_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            md_q         <= md_d;
            fdone_pend_q <= fdone_pend_d;
            frame_done_q <= frame_done_d;
            cnt_q        <= cnt_d;
            mcount_q     <= mcount_d;
        end
    end

    assign vec_we          = we_q;
    assign vec_addr        = addr_q;
    assign motion_detected = md_q;
    assign frame_done      = frame_done_q;
    assign motion_count    = mcount_q;

endmodule

// File: tb/tb_tile_motion_vecgen.sv
// Bench for tile_motion_vecgen in the 64x32 / 4x4-tile configuration:
// directed frame table, random frames against a tile-sum model, reset mid-burst.
module tb_tile_motion_vecgen;

    localparam int HA     = 64;
    localparam int VA     = 32;
    localparam int NGX    = 4;
    localparam int NGY    = 4;
    localparam int TWB    = HA / NGX;
    localparam int THB    = VA / NGY;
    localparam int THR    = 1000;
    localparam int NT     = NGX * NGY;
    localparam int HBLANK = 16;
    localparam int VBLANK = 24;

    typedef struct {
        int          mode;      // 0: flat grey + delta in one tile, 1: random
        int          base;
        int          dty;
        int          dtx;
        int          delta;
        logic [15:0] mask;
        int          cnt;
        bit          directed;
    } vec_t;

    typedef struct {
        logic [7:0] addr;
        logic       md;
        int         c;
    } pulse_t;

    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] s_pData = '0;
    logic        s_pVDE = 1'b0;
    logic        vec_we;
    logic [7:0]  vec_addr;
    logic        motion_detected;
    logic        frame_done;
    logic [8:0]  motion_count;

    tile_motion_vecgen #(
        .H_ACTIVE (HA),
        .V_ACTIVE (VA),
        .GX       (NGX),
        .GY       (NGY),
        .THRESH   (THR)
    ) dut (
        .pclk            (pclk),
        .rst_n           (rst_n),
        .s_pData         (s_pData),
        .s_pVDE          (s_pVDE),
        .vec_we          (vec_we),
        .vec_addr        (vec_addr),
        .motion_detected (motion_detected),
        .frame_done      (frame_done),
        .motion_count    (motion_count)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    pulse_t pq[$];
    int     fdq[$];
    int     fallq[$];

    always @(negedge pclk) begin : mon
        pulse_t p;
        if (vec_we) begin
            p.addr = vec_addr;
            p.md   = motion_detected;
            p.c    = cyc;
            pq.push_back(p);
        end
        if (frame_done) fdq.push_back(cyc);
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [23:0] img [VA][HA];
    int          prev_sum [NT];
    bit          pv;
    bit          exp_flag [NT];
    int          exp_cnt;

    function automatic int luma_ref(input logic [23:0] p);
        return (int'(p[23:16]) + 2 * int'(p[15:8]) + int'(p[7:0])) / 4;
    endfunction

    task automatic build_grey(input int base, input int dty, input int dtx, input int delta);
        int rem, v, step;
        for (int y = 0; y < VA; y++)
            for (int x = 0; x < HA; x++)
                img[y][x] = {8'(base), 8'(base), 8'(base)};
        rem = delta;
        for (int yy = 0; yy < THB; yy++) begin
            for (int xx = 0; xx < TWB; xx++) begin
                v = base;
                if (rem > 0) begin
                    step = (rem > 255 - base) ? 255 - base : rem;
                    v += step;
                    rem -= step;
                end else if (rem < 0) begin
                    step = (-rem > base) ? base : -rem;
                    v -= step;
                    rem += step;
                end
                img[dty * THB + yy][dtx * TWB + xx] = {8'(v), 8'(v), 8'(v)};
            end
        end
    endtask

    task automatic build_random();
        for (int y = 0; y < VA; y++)
            for (int x = 0; x < HA; x++)
                img[y][x] = 24'($urandom);
    endtask

    task automatic model_frame();
        int s [NT];
        int d;
        for (int t = 0; t < NT; t++) s[t] = 0;
        for (int y = 0; y < VA; y++)
            for (int x = 0; x < HA; x++)
                s[(y / THB) * NGX + (x / TWB)] += luma_ref(img[y][x]);
        exp_cnt = 0;
        for (int t = 0; t < NT; t++) begin
            d = s[t] - prev_sum[t];
            if (d < 0) d = -d;
            exp_flag[t] = pv && (d > THR);
            if (exp_flag[t]) exp_cnt++;
            prev_sum[t] = s[t];
        end
        pv = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    task automatic drive_line(input int y);
        for (int x = 0; x < HA; x++) begin
            @(posedge pclk); #1;
            s_pVDE  = 1'b1;
            s_pData = img[y][x];
        end
        @(posedge pclk); #1;
        s_pVDE  = 1'b0;
        s_pData = '0;
        if (y % THB == THB - 1) fallq.push_back(cyc);
    endtask

    task automatic drive_frame();
        for (int y = 0; y < VA; y++) begin
            drive_line(y);
            repeat (HBLANK - 1) @(posedge pclk);
        end
        repeat (VBLANK) @(posedge pclk);
        #1;
    endtask

    task automatic check_frame(input string tag, input bit directed,
                               input logic [15:0] mask_exp, input int cnt_exp);
        pulse_t p;
        int     last_c;
        int     exp_c;
        int     t;
        last_c = 0;
        for (int ty = 0; ty < NGY; ty++) begin
            for (int tx = 0; tx < NGX; tx++) begin
                t = ty * NGX + tx;
                if (pq.size() == 0) begin
                    chk({tag, "_pulse_missing"}, 0, 1);
                end else begin
                    p = pq.pop_front();
                    chk({tag, "_addr"}, int'(p.addr), ty * 16 + tx);
                    chk({tag, "_motion"}, int'(p.md),
                        directed ? int'(mask_exp[t]) : int'(exp_flag[t]));
                    if (tx == 0) exp_c = (ty < fallq.size()) ? fallq[ty] + 3 : -1;
                    else         exp_c = last_c + 1;
                    chk({tag, "_timing"}, p.c, exp_c);
                    last_c = p.c;
                end
            end
        end
        chk({tag, "_extra_pulses"}, pq.size(), 0);
        chk({tag, "_frame_done_n"}, fdq.size(), 1);
        if (fdq.size() > 0) chk({tag, "_frame_done_cyc"}, fdq[0], last_c + 1);
        chk({tag, "_motion_count"}, int'(motion_count), directed ? cnt_exp : exp_cnt);
        pq.delete();
        fdq.delete();
        fallq.delete();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [10];
        tbl[0] = '{0, 128, 0, 0,     0, 16'h0000, 0, 1'b1};
        tbl[1] = '{0, 128, 2, 1, 16256, 16'h0200, 1, 1'b1};
        tbl[2] = '{0, 128, 0, 0,     0, 16'h0200, 1, 1'b1};
        tbl[3] = '{0, 128, 1, 3,  1000, 16'h0000, 0, 1'b1};
        tbl[4] = '{0, 128, 1, 3,    -1, 16'h0080, 1, 1'b1};
        tbl[5] = '{0, 128, 1, 3,   999, 16'h0000, 0, 1'b1};
        tbl[6] = '{0, 128, 3, 0,  1001, 16'h1000, 1, 1'b1};
        tbl[7] = '{1,   0, 0, 0,     0, 16'h0000, 0, 1'b0};
        tbl[8] = '{1,   0, 0, 0,     0, 16'h0000, 0, 1'b0};
        tbl[9] = '{1,   0, 0, 0,     0, 16'h0000, 0, 1'b0};

        pv = 1'b0;
        for (int t = 0; t < NT; t++) prev_sum[t] = 0;

        rst_n = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        chk("reset_vec_we", int'(vec_we), 0);
        chk("reset_vec_addr", int'(vec_addr), 0);
        chk("reset_motion", int'(motion_detected), 0);
        chk("reset_frame_done", int'(frame_done), 0);
        chk("reset_motion_count", int'(motion_count), 0);
        rst_n = 1'b1;
        repeat (4) @(posedge pclk);
        #1;

        for (int i = 0; i < 10; i++) begin
            if (tbl[i].mode == 0) build_grey(tbl[i].base, tbl[i].dty, tbl[i].dtx, tbl[i].delta);
            else                  build_random();
            model_frame();
            drive_frame();
            check_frame($sformatf("frame%0d", i), tbl[i].directed, tbl[i].mask, tbl[i].cnt);
        end

        // Reset during the second pulse of row 1 of a partly sent frame.
        build_random();
        for (int y = 0; y < 2 * THB; y++) begin
            drive_line(y);
            if (y < 2 * THB - 1) repeat (HBLANK - 1) @(posedge pclk);
        end
        repeat (4) @(posedge pclk);
        #2;
        chk("midrst_pulse2_we", int'(vec_we), 1);
        chk("midrst_pulse2_addr", int'(vec_addr), 8'h11);
        rst_n = 1'b0;
        #1;
        chk("midrst_vec_we", int'(vec_we), 0);
        chk("midrst_vec_addr", int'(vec_addr), 0);
        chk("midrst_motion", int'(motion_detected), 0);
        chk("midrst_motion_count", int'(motion_count), 0);
        repeat (3) @(posedge pclk);
        #1;
        rst_n = 1'b1;
        pq.delete();
        fdq.delete();
        fallq.delete();
        pv = 1'b0;
        repeat (4) @(posedge pclk);
        #1;

        build_grey(255, 0, 0, 0);
        model_frame();
        drive_frame();
        check_frame("post_rst_white", 1'b0, 16'h0000, 0);

        build_grey(0, 0, 0, 0);
        model_frame();
        drive_frame();
        check_frame("post_rst_black", 1'b0, 16'h0000, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
